// File: rtl/fpu_regs_mp.sv
// Multi-port FP register file with per-register format tags, a pending-write
// scoreboard and an FCSR that accumulates sticky exception flags.
module fpu_regs_mp #(
  parameter int                 REG_NUM   = 32,
  parameter int                 DATA_W    = 32,
  parameter int                 FMT_W     = 3,
  parameter int                 NR        = 3,
  parameter int                 NW        = 2,
  parameter logic [FMT_W-1:0]   FMT_RESET = '0,
  parameter logic [31:0]        FCCR_VAL  = 32'h0001_0000,
  localparam int                AW        = $clog2(REG_NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NW-1:0]        wr_we,
  input  logic [NW*AW-1:0]     wr_addr,
  input  logic [NW*DATA_W-1:0] wr_data,
  input  logic [NW*FMT_W-1:0]  wr_fmt,
  input  logic [NR*AW-1:0]     rd_addr,
  output logic [NR*DATA_W-1:0] rd_data,
  output logic [NR*FMT_W-1:0]  rd_fmt,
  output logic [NR-1:0]        rd_busy,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr,
  input  logic                 fcsr_we,
  input  logic [31:0]          fcsr_wdata,
  input  logic                 exc_valid,
  input  logic [5:0]           exc_cause,
  output logic [31:0]          fcsr,
  output logic [31:0]          fccr,
  output logic                 fpe_pending
);

  logic [DATA_W-1:0]  regs [REG_NUM];
  logic [FMT_W-1:0]   fmts [REG_NUM];
  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] written;
  logic [REG_NUM-1:0] set_mask;
  logic [31:0]        fcsr_q;
  logic [31:0]        fcsr_next;

  // Only in-range indices are decoded, so out-of-range write addresses hit nothing.
  always_comb begin
    written  = '0;
    set_mask = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      for (int k = 0; k < NW; k++) begin
        if (wr_we[k] && wr_addr[k*AW +: AW] == AW'(i)) written[i] = 1'b1;
      end
      if (sb_set && sb_addr == AW'(i)) set_mask[i] = 1'b1;
    end
  end

  // Later ports are assigned last, so the highest-index port wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
        fmts[i] <= FMT_RESET;
      end
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        for (int k = 0; k < NW; k++) begin
          if (wr_we[k] && wr_addr[k*AW +: AW] == AW'(i)) begin
            regs[i] <= wr_data[k*DATA_W +: DATA_W];
            fmts[i] <= wr_fmt[k*FMT_W +: FMT_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= '0;
      fcsr_q <= '0;
    end else begin
      busy   <= (busy & ~written) | set_mask;
      fcsr_q <= fcsr_next;
    end
  end

  always_comb begin
    fcsr_next = fcsr_q;
    if (fcsr_we) begin
      fcsr_next = fcsr_wdata;
    end else if (exc_valid) begin
      fcsr_next[17:12] = exc_cause;
      fcsr_next[6:2]   = fcsr_q[6:2] | exc_cause[4:0];
    end
  end

  always_comb begin
    logic [AW-1:0] ra;
    ra      = '0;
    rd_data = '0;
    rd_fmt  = '0;
    rd_busy = '0;
    for (int j = 0; j < NR; j++) begin
      ra = rd_addr[j*AW +: AW];
      rd_data[j*DATA_W +: DATA_W] = regs[ra];
      rd_fmt[j*FMT_W +: FMT_W]    = fmts[ra];
      for (int k = 0; k < NW; k++) begin
        if (wr_we[k] && wr_addr[k*AW +: AW] == ra) begin
          rd_data[j*DATA_W +: DATA_W] = wr_data[k*DATA_W +: DATA_W];
          rd_fmt[j*FMT_W +: FMT_W]    = wr_fmt[k*FMT_W +: FMT_W];
        end
      end
      rd_busy[j] = busy[ra] & ~written[ra];
    end
  end

  assign fcsr        = fcsr_we ? fcsr_wdata : fcsr_q;
  assign fpe_pending = fcsr[17] | (|(fcsr[16:12] & fcsr[11:7]));
  assign fccr        = FCCR_VAL;

endmodule

// File: tb/tb_fpu_regs_mp.sv
// Scoreboard bench for fpu_regs_mp: a behavioural model queues expected
// outputs per cycle and an independent monitor compares them at negedge.
module tb_fpu_regs_mp;
  localparam int REG_NUM = 32;
  localparam int DATA_W  = 32;
  localparam int FMT_W   = 3;
  localparam int NR      = 3;
  localparam int NW      = 2;
  localparam int AW      = 5;

  logic                 clk;
  logic                 rst_n;
  logic [NW-1:0]        wr_we;
  logic [NW*AW-1:0]     wr_addr;
  logic [NW*DATA_W-1:0] wr_data;
  logic [NW*FMT_W-1:0]  wr_fmt;
  logic [NR*AW-1:0]     rd_addr;
  logic [NR*DATA_W-1:0] rd_data;
  logic [NR*FMT_W-1:0]  rd_fmt;
  logic [NR-1:0]        rd_busy;
  logic                 sb_set;
  logic [AW-1:0]        sb_addr;
  logic                 fcsr_we;
  logic [31:0]          fcsr_wdata;
  logic                 exc_valid;
  logic [5:0]           exc_cause;
  logic [31:0]          fcsr;
  logic [31:0]          fccr;
  logic                 fpe_pending;

  fpu_regs_mp #(
    .REG_NUM(REG_NUM), .DATA_W(DATA_W), .FMT_W(FMT_W), .NR(NR), .NW(NW),
    .FMT_RESET(3'd0), .FCCR_VAL(32'h0001_0000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_we(wr_we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_fmt(wr_fmt),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_fmt(rd_fmt), .rd_busy(rd_busy),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .fcsr_we(fcsr_we), .fcsr_wdata(fcsr_wdata),
    .exc_valid(exc_valid), .exc_cause(exc_cause),
    .fcsr(fcsr), .fccr(fccr), .fpe_pending(fpe_pending)
  );

  typedef struct {
    logic [NR*DATA_W-1:0] data;
    logic [NR*FMT_W-1:0]  fmt;
    logic [NR-1:0]        busy;
    logic [31:0]          fcsr;
    logic                 pend;
  } exp_t;

  exp_t expQ[$];
  int   vectors     = 0;
  int   miscompares = 0;

  logic [DATA_W-1:0] mMem  [REG_NUM];
  logic [FMT_W-1:0]  mFmt  [REG_NUM];
  bit                mBusy [REG_NUM];
  logic [31:0]       mFcsr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: drains every queued expectation against the settled outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        for (int j = 0; j < NR; j++) begin
          checkOutput($sformatf("rd_data[%0d]", j), rd_data[j*DATA_W +: DATA_W], e.data[j*DATA_W +: DATA_W]);
          checkOutput($sformatf("rd_fmt[%0d]", j), 32'(rd_fmt[j*FMT_W +: FMT_W]), 32'(e.fmt[j*FMT_W +: FMT_W]));
          checkOutput($sformatf("rd_busy[%0d]", j), 32'(rd_busy[j]), 32'(e.busy[j]));
        end
        checkOutput("fcsr", fcsr, e.fcsr);
        checkOutput("fpe_pending", 32'(fpe_pending), 32'(e.pend));
        checkOutput("fccr", fccr, 32'h0001_0000);
      end
    end
  end

  // Predicts this cycle's outputs, queues them, then advances the model one clock.
  task automatic applyStimulus();
    exp_t              e;
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] d;
    logic [FMT_W-1:0]  f;
    bit                written [REG_NUM];
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        mMem[i]  = '0;
        mFmt[i]  = '0;
        mBusy[i] = 1'b0;
      end
      mFcsr = '0;
    end
    for (int i = 0; i < REG_NUM; i++) written[i] = 1'b0;
    for (int k = 0; k < NW; k++) if (wr_we[k]) written[wr_addr[k*AW +: AW]] = 1'b1;
    for (int j = 0; j < NR; j++) begin
      a = rd_addr[j*AW +: AW];
      d = mMem[a];
      f = mFmt[a];
      for (int k = 0; k < NW; k++) begin
        if (wr_we[k] && wr_addr[k*AW +: AW] == a) begin
          d = wr_data[k*DATA_W +: DATA_W];
          f = wr_fmt[k*FMT_W +: FMT_W];
        end
      end
      e.data[j*DATA_W +: DATA_W] = d;
      e.fmt[j*FMT_W +: FMT_W]    = f;
      e.busy[j]                  = mBusy[a] && !written[a];
    end
    e.fcsr = fcsr_we ? fcsr_wdata : mFcsr;
    e.pend = e.fcsr[17] || ((e.fcsr[16:12] & e.fcsr[11:7]) != 5'd0);
    expQ.push_back(e);
    if (rst_n) begin
      for (int k = 0; k < NW; k++) begin
        if (wr_we[k]) begin
          mMem[wr_addr[k*AW +: AW]] = wr_data[k*DATA_W +: DATA_W];
          mFmt[wr_addr[k*AW +: AW]] = wr_fmt[k*FMT_W +: FMT_W];
        end
      end
      for (int i = 0; i < REG_NUM; i++) if (written[i]) mBusy[i] = 1'b0;
      if (sb_set) mBusy[sb_addr] = 1'b1;
      if (fcsr_we) begin
        mFcsr = fcsr_wdata;
      end else if (exc_valid) begin
        mFcsr[17:12] = exc_cause;
        mFcsr[6:2]   = mFcsr[6:2] | exc_cause[4:0];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_we      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_fmt     = '0;
    sb_set     = 1'b0;
    sb_addr    = '0;
    fcsr_we    = 1'b0;
    fcsr_wdata = '0;
    exc_valid  = 1'b0;
    exc_cause  = '0;
  endtask

  task automatic setRead(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  task automatic setWrite(input int k, input logic [AW-1:0] addr, input logic [DATA_W-1:0] data,
                          input logic [FMT_W-1:0] fmt);
    wr_we[k]                  = 1'b1;
    wr_addr[k*AW +: AW]       = addr;
    wr_data[k*DATA_W +: DATA_W] = data;
    wr_fmt[k*FMT_W +: FMT_W]  = fmt;
  endtask

  initial begin
    rst_n   = 1'b1;
    rd_addr = '0;
    idle();
    @(posedge clk);
    #1;

    rst_n = 1'b0;
    setRead(5'd0, 5'd5, 5'd31);
    applyStimulus();
    applyStimulus();
    rst_n = 1'b1;
    applyStimulus();

    setRead(5'd4, 5'd4, 5'd0);
    setWrite(0, 5'd4, 32'h3F80_0000, 3'd1);
    applyStimulus();
    idle();
    applyStimulus();

    setRead(5'd7, 5'd4, 5'd0);
    setWrite(0, 5'd7, 32'h1111_1111, 3'd2);
    setWrite(1, 5'd7, 32'h2222_2222, 3'd3);
    applyStimulus();
    idle();
    applyStimulus();

    setRead(5'd9, 5'd9, 5'd7);
    sb_set = 1'b1; sb_addr = 5'd9;
    applyStimulus();
    idle();
    applyStimulus();
    setWrite(1, 5'd9, 32'hDEAD_BEEF, 3'd2);
    applyStimulus();
    idle();
    applyStimulus();
    sb_set = 1'b1; sb_addr = 5'd9;
    setWrite(0, 5'd9, 32'h0BAD_F00D, 3'd4);
    applyStimulus();
    idle();
    applyStimulus();

    fcsr_we = 1'b1; fcsr_wdata = 32'h0000_0080;
    applyStimulus();
    idle();
    exc_valid = 1'b1; exc_cause = 6'b010000;
    applyStimulus();
    idle();
    applyStimulus();
    exc_valid = 1'b1; exc_cause = 6'b000001;
    applyStimulus();
    idle();
    exc_valid = 1'b1; exc_cause = 6'b100000;
    applyStimulus();
    idle();
    exc_valid = 1'b1; exc_cause = 6'b000000;
    applyStimulus();
    idle();
    applyStimulus();
    fcsr_we = 1'b1; fcsr_wdata = 32'h0000_0003;
    exc_valid = 1'b1; exc_cause = 6'b111111;
    applyStimulus();
    idle();
    applyStimulus();

    sb_set = 1'b1; sb_addr = 5'd7;
    fcsr_we = 1'b1; fcsr_wdata = 32'h0003_FFFF;
    applyStimulus();
    idle();
    rst_n = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
    setWrite(0, 5'd9, 32'h1234_5678, 3'd5);
    applyStimulus();
    idle();
    applyStimulus();

    for (int n = 0; n < 400; n++) begin
      logic narrow;
      idle();
      narrow = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NW; k++) begin
        if ($urandom_range(0, 1) == 1)
          setWrite(k, narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, REG_NUM-1)),
                   DATA_W'($urandom()), FMT_W'($urandom_range(0, 7)));
      end
      setRead(narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, REG_NUM-1)),
              AW'($urandom_range(0, 7)), AW'($urandom_range(0, REG_NUM-1)));
      sb_set  = ($urandom_range(0, 2) == 0);
      sb_addr = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, REG_NUM-1));
      fcsr_we = ($urandom_range(0, 15) == 0);
      fcsr_wdata = $urandom();
      exc_valid  = ($urandom_range(0, 2) == 0);
      exc_cause  = 6'($urandom_range(0, 63));
      applyStimulus();
    end
    idle();
    applyStimulus();

    @(negedge clk);
    #1;
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
